// File: rtl/io_controller_pkg.sv
// Shared constants and helpers for the memory-mapped I/O controller.
package io_controller_pkg;

    // Register offsets within the I/O region (low address bits only).
    localparam int unsigned IO_CTRL      = 32'h00;
    localparam int unsigned IO_RX_DATA   = 32'h04;
    localparam int unsigned IO_TX_DATA   = 32'h08;
    localparam int unsigned IO_CYCLE_CNT = 32'h10;
    localparam int unsigned IO_INSTR_CNT = 32'h14;
    localparam int unsigned IO_CNT_RST   = 32'h18;

    // Decoded register select.
    typedef enum logic [2:0] {
        RegNone,
        RegCtrl,
        RegRxData,
        RegTxData,
        RegCycleCnt,
        RegInstrCnt,
        RegCntRst
    } io_reg_e;

    // Map a zero-extended offset onto a register select; unmapped offsets give RegNone.
    function automatic io_reg_e decode_offset(input int unsigned ofs);
        io_reg_e sel;
        sel = RegNone;
        case (ofs)
            IO_CTRL:      sel = RegCtrl;
            IO_RX_DATA:   sel = RegRxData;
            IO_TX_DATA:   sel = RegTxData;
            IO_CYCLE_CNT: sel = RegCycleCnt;
            IO_INSTR_CNT: sel = RegInstrCnt;
            IO_CNT_RST:   sel = RegCntRst;
            default:      sel = RegNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_controller_counters.sv
// Free-running cycle counter and retired-instruction counter with synchronous clear.
module io_counters
    import io_controller_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            instr_retire,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instr_cnt
);

    logic [XLEN-1:0] cycle_q, cycle_d;
    logic [XLEN-1:0] instr_q, instr_d;

    // Next counter values; a clear beats the increment in the same cycle.
    always_comb begin
        cycle_d = cycle_q + XLEN'(1);
        instr_d = instr_q + XLEN'(instr_retire);
        if (clr) begin
            cycle_d = '0;
            instr_d = '0;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: UART RX/TX holding registers, counters, registered read port.
module io_controller
    import io_controller_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFS_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] io_adr,
    input  logic            io_we,
    input  logic            io_re,
    input  logic [XLEN-1:0] io_wdata,
    output logic [XLEN-1:0] io_rdata,
    input  logic            instr_retire,
    output logic [7:0]      uart_tx_data,
    output logic            uart_tx_valid,
    input  logic            uart_tx_ready,
    input  logic [7:0]      uart_rx_data,
    input  logic            uart_rx_valid,
    output logic            uart_rx_ready
);

    io_reg_e         sel;
    logic            tx_wr, cnt_clr, rx_rd;
    logic            rx_accept, tx_hs;
    logic            rx_full_q, rx_full_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            tx_pending_q, tx_pending_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [XLEN-1:0] rdata_mux;
    logic [XLEN-1:0] io_rdata_q, io_rdata_d;
    logic [XLEN-1:0] cycle_cnt, instr_cnt;

    // Address bits above the decoded offset and the upper store-data bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{io_adr[XLEN-1:OFS_W], io_wdata[XLEN-1:8]};

    assign sel     = decode_offset(32'(io_adr[OFS_W-1:0]));
    assign tx_wr   = io_we && (sel == RegTxData);
    assign cnt_clr = io_we && (sel == RegCntRst);
    assign rx_rd   = io_re && (sel == RegRxData);

    assign rx_accept = uart_rx_valid && !rx_full_q;
    assign tx_hs     = tx_pending_q && uart_tx_ready;

    // RX holding register: a read drains it; a byte lands only while empty.
    always_comb begin
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        if (rx_rd) begin
            rx_full_d = 1'b0;
        end
        // Only possible while empty, so it never collides with a draining read.
        if (rx_accept) begin
            rx_byte_d = uart_rx_data;
            rx_full_d = 1'b1;
        end
    end

    // TX holding register: writes while a byte is pending are dropped.
    always_comb begin
        tx_pending_d = tx_pending_q;
        tx_byte_d    = tx_byte_q;
        if (tx_hs) begin
            tx_pending_d = 1'b0;
        end else if (tx_wr && !tx_pending_q) begin
            tx_byte_d    = io_wdata[7:0];
            tx_pending_d = 1'b1;
        end
    end

    // Read mux over pre-update register values.
    always_comb begin
        rdata_mux = '0;
        case (sel)
            RegCtrl:     rdata_mux = {{(XLEN-2){1'b0}}, rx_full_q, !tx_pending_q};
            RegRxData:   rdata_mux = {{(XLEN-8){1'b0}}, rx_byte_q};
            RegCycleCnt: rdata_mux = cycle_cnt;
            RegInstrCnt: rdata_mux = instr_cnt;
            default:     rdata_mux = '0;
        endcase
        io_rdata_d = io_re ? rdata_mux : io_rdata_q;
    end

    // UART holding registers and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_q    <= 1'b0;
            rx_byte_q    <= '0;
            tx_pending_q <= 1'b0;
            tx_byte_q    <= '0;
            io_rdata_q   <= '0;
        end else begin
            rx_full_q    <= rx_full_d;
            rx_byte_q    <= rx_byte_d;
            tx_pending_q <= tx_pending_d;
            tx_byte_q    <= tx_byte_d;
            io_rdata_q   <= io_rdata_d;
        end
    end

    io_counters #(
        .XLEN (XLEN)
    ) u_counters (
        .clk          (clk),
        .rst          (rst),
        .clr          (cnt_clr),
        .instr_retire (instr_retire),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

    assign io_rdata      = io_rdata_q;
    assign uart_tx_valid = tx_pending_q;
    assign uart_tx_data  = tx_byte_q;
    assign uart_rx_ready = !rx_full_q;

endmodule
